// File: rtl/bsg_credit_pool_rr_arbiter.sv
// Round-robin arbiter that shares one credit-flow-controlled output among els_p requesters.
// Define BSG_CREDIT_POOL_OVERFLOW_CHK_EN to add a sticky credit-overflow flag on error_o.
module bsg_credit_pool_rr_arbiter #(
  parameter int els_p            = 4,
  parameter int credit_max_val_p = 150,
  parameter int credit_initial_p = 1,
  localparam int cnt_width_lp    = $clog2(credit_max_val_p + 1),
  localparam int ptr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [els_p-1:0]        v_i,
  output logic [els_p-1:0]        ready_o,
  output logic                    v_o,
  output logic [els_p-1:0]        sel_one_hot_o,
  input  logic                    credit_i,
  output logic [cnt_width_lp-1:0] credit_cnt_o
`ifdef BSG_CREDIT_POOL_OVERFLOW_CHK_EN
  , output logic                  error_o
`endif
);

  localparam logic [cnt_width_lp-1:0] cnt_max_lp  = cnt_width_lp'(credit_max_val_p);
  localparam logic [cnt_width_lp-1:0] cnt_init_lp = cnt_width_lp'(credit_initial_p);
  localparam logic [ptr_width_lp-1:0] ptr_last_lp = ptr_width_lp'(els_p - 1);

  logic [cnt_width_lp-1:0] cnt_r;
  logic [ptr_width_lp-1:0] ptr_r;
  logic [ptr_width_lp-1:0] winner;
  logic [els_p-1:0]        below_ptr_mask;
  logic [els_p-1:0]        at_or_above;
  logic [els_p-1:0]        pick;
  logic [els_p-1:0]        grant;
  logic                    have_credit;
  logic                    send;

  // Requests at or above the pointer win first; otherwise wrap to the lowest set request.
  always_comb begin
    below_ptr_mask = (els_p'(1) << ptr_r) - els_p'(1);
    at_or_above    = v_i & ~below_ptr_mask;
    pick           = (at_or_above != '0) ? at_or_above : v_i;
    grant          = pick & (~pick + els_p'(1));
    winner         = '0;
    for (int k = 0; k < els_p; k++) begin
      if (grant[k]) winner = ptr_width_lp'(k);
    end
  end

  assign have_credit   = (cnt_r != '0);
  assign send          = have_credit & (v_i != '0);
  assign v_o           = send;
  assign ready_o       = send ? grant : '0;
  assign sel_one_hot_o = send ? grant : '0;
  assign credit_cnt_o  = cnt_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_r <= '0;
    end else if (send) begin
      ptr_r <= (winner == ptr_last_lp) ? '0 : winner + ptr_width_lp'(1);
    end
  end

  // A returned credit and a send in the same cycle cancel out.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_r <= cnt_init_lp;
    end else if (send && !credit_i) begin
      cnt_r <= cnt_r - cnt_width_lp'(1);
    end else if (!send && credit_i && (cnt_r != cnt_max_lp)) begin
      cnt_r <= cnt_r + cnt_width_lp'(1);
    end
  end

`ifdef BSG_CREDIT_POOL_OVERFLOW_CHK_EN
  logic error_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      error_r <= 1'b0;
    end else if (!send && credit_i && (cnt_r == cnt_max_lp)) begin
      error_r <= 1'b1;
    end
  end

  assign error_o = error_r;
`endif

endmodule
